// File: rtl/fifo_get_arbiter_pkg.sv
// Shared definitions for the FIFO GET arbiter.
// Contents:
//   arb_state_t       - arbiter FSM states (ARB_IDLE, ARB_BURST)
//   DEF_*             - default values for the top-level parameters
//   clog2_min1()      - bit width for an index, never less than 1
package fifo_get_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_DW        = 32;
    localparam int DEF_BURST_LEN = 8;
    localparam int DEF_READ_LAT  = 1;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/fifo_get_arbiter_rr_priority_select.sv
// Round-robin priority selector (purely combinational).
// Scans req starting at start and wrapping modulo N_REQ; reports the first
// requesting index.
// Ports:
//   req    in   N_REQ  request vector
//   start  in   PW     scan start position (must be < N_REQ)
//   index  out  PW     first requesting index at or after start
//   found  out  1      1 when any request bit is set
module rr_priority_select #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    start,
    output logic [PW-1:0]    index,
    output logic             found
);

    int pos;

    // NOTE: every combinationally assigned signal gets a default before any
    // conditional assignment, so no path leaves it unassigned (no latch).
    always_comb begin
        index = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            // Explicit wrap instead of a modulo so non-power-of-2 N_REQ works.
            pos = int'(start) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (!found && req[PW'(pos)]) begin
                found = 1'b1;
                index = PW'(pos);
            end
        end
    end

endmodule

// File: rtl/fifo_get_arbiter.sv
// Shares one input-FIFO read port between N_REQ streaming cores.
// Round-robin grant with a bounded burst of at most BURST_LEN reads; each
// returned word is tagged with a one-hot valid for the core that read it,
// READ_LAT cycles after its read strobe.
// Ports:
//   clk           in   1      clock, all state on rising edge
//   reset         in   1      synchronous, active-high reset
//   req           in   N_REQ  per-core read request (level)
//   empty         in   1      shared FIFO empty flag
//   fifo_dout     in   DW     shared FIFO read data
//   fifo_read_en  out  1      FIFO read strobe (combinational)
//   grant         out  N_REQ  one-hot current owner, registered; 0 when idle
//   data_out      out  DW     fifo_dout broadcast to all cores
//   valid_out     out  N_REQ  one-hot owner of data_out this cycle
//   busy          out  1      1 while in the burst state
module fifo_get_arbiter
    import fifo_get_arbiter_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int DW        = DEF_DW,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int READ_LAT  = DEF_READ_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             empty,
    input  logic [DW-1:0]    fifo_dout,
    output logic             fifo_read_en,
    output logic [N_REQ-1:0] grant,
    output logic [DW-1:0]    data_out,
    output logic [N_REQ-1:0] valid_out,
    output logic             busy
);

    localparam int PW = clog2_min1(N_REQ);
    localparam int CW = clog2_min1(BURST_LEN);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

    arb_state_t       state, state_n;
    logic [PW-1:0]    owner, owner_n;
    logic [PW-1:0]    rr_ptr, rr_ptr_n;
    logic [CW-1:0]    count, count_n;
    logic [N_REQ-1:0] grant_n;
    logic [PW-1:0]    sel_idx;
    logic             sel_found;
    logic             owner_req;
    logic             rd;
    logic             burst_done;

    // Tag pipe: stage i holds the read issued i+1 cycles ago.
    logic [READ_LAT-1:0] tag_vld;
    logic [PW-1:0]       tag_own [READ_LAT];

    rr_priority_select #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_select (
        .req   (req),
        .start (rr_ptr),
        .index (sel_idx),
        .found (sel_found)
    );

    assign owner_req    = req[owner];
    // Reads only in BURST; reset masks the strobe so nothing is popped while
    // the arbiter is being cleared.
    assign rd           = (state == ARB_BURST) && owner_req && !empty && !reset;
    assign fifo_read_en = rd;
    assign data_out     = fifo_dout;
    assign busy         = (state == ARB_BURST);

    // Burst ends on the last permitted read, or when the owner withdraws its
    // request. An empty stall with the request still up simply holds.
    assign burst_done = (rd && (count == LAST_CNT)) || (!rd && !owner_req);

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        rr_ptr_n = rr_ptr;
        count_n  = count;
        grant_n  = grant;
        case (state)
            ARB_IDLE: begin
                if (sel_found) begin
                    state_n          = ARB_BURST;
                    owner_n          = sel_idx;
                    count_n          = '0;
                    grant_n          = '0;
                    grant_n[sel_idx] = 1'b1;
                end
            end
            ARB_BURST: begin
                if (rd) begin
                    count_n = count + 1'b1;
                end
                if (burst_done) begin
                    state_n  = ARB_IDLE;
                    grant_n  = '0;
                    rr_ptr_n = (owner == LAST_IDX) ? '0 : owner + 1'b1;
                end
            end
            default: begin
                state_n = ARB_IDLE;
                grant_n = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ARB_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            count  <= '0;
            grant  <= '0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            rr_ptr <= rr_ptr_n;
            count  <= count_n;
            grant  <= grant_n;
        end
    end

    // NOTE: the tag pipe is reset as a whole, not just its valid bits, so
    // in-flight tags are discarded and no stale owner index survives reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                tag_own[i] <= '0;
            end
        end else begin
            tag_vld[0] <= rd;
            tag_own[0] <= owner;
            for (int i = 1; i < READ_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_own[i] <= tag_own[i-1];
            end
        end
    end

    always_comb begin
        valid_out = '0;
        if (tag_vld[READ_LAT-1]) begin
            valid_out[tag_own[READ_LAT-1]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_get_arbiter.sv
// Directed self-checking bench for fifo_get_arbiter.
// Three instances share clock, reset, empty and FIFO data:
//   dut_a  N_REQ=4, READ_LAT=1   (main function, stalls, request drop)
//   dut_b  N_REQ=4, READ_LAT=2   (reset with tags in flight)
//   dut_c  N_REQ=3, READ_LAT=1   (non-power-of-2 pointer wrap)
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit later, well before the next edge.
module tb_fifo_get_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        empty;
    logic [31:0] fifo_dout;

    logic [3:0]  req_a, grant_a, valid_a;
    logic [31:0] data_a;
    logic        rd_a, busy_a;

    logic [3:0]  req_b, grant_b, valid_b;
    logic [31:0] data_b;
    logic        rd_b, busy_b;

    logic [2:0]  req_c, grant_c, valid_c;
    logic [31:0] data_c;
    logic        rd_c, busy_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fifo_get_arbiter #(.N_REQ(4), .DW(32), .BURST_LEN(8), .READ_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .empty(empty), .fifo_dout(fifo_dout),
        .fifo_read_en(rd_a), .grant(grant_a), .data_out(data_a),
        .valid_out(valid_a), .busy(busy_a)
    );

    fifo_get_arbiter #(.N_REQ(4), .DW(32), .BURST_LEN(8), .READ_LAT(2)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .empty(empty), .fifo_dout(fifo_dout),
        .fifo_read_en(rd_b), .grant(grant_b), .data_out(data_b),
        .valid_out(valid_b), .busy(busy_b)
    );

    fifo_get_arbiter #(.N_REQ(3), .DW(32), .BURST_LEN(8), .READ_LAT(1)) dut_c (
        .clk(clk), .reset(reset), .req(req_c), .empty(empty), .fifo_dout(fifo_dout),
        .fifo_read_en(rd_c), .grant(grant_c), .data_out(data_c),
        .valid_out(valid_c), .busy(busy_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [3:0] exp_g;
        logic [2:0] exp_c [4];

        reset     = 1'b1;
        empty     = 1'b0;
        fifo_dout = 32'h0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;

        // ---- reset state, lone requester core 0 ----
        tick();
        tick();
        reset = 1'b0;
        settle();
        check("rst_grant", grant_a, 4'b0000);
        check("rst_valid", valid_a, 4'b0000);
        check("rst_busy", busy_a, 1'b0);
        check("rst_rd", rd_a, 1'b0);

        req_a     = 4'b0001;
        fifo_dout = 32'hA5A5_0001;
        settle();
        check("t1_no_read_in_idle", rd_a, 1'b0);
        check("t1_data_passthrough", data_a, 32'hA5A5_0001);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("t1_grant", grant_a, 4'b0001);
            check("t1_rd", rd_a, 1'b1);
            check("t1_valid", valid_a, (i == 0) ? 4'b0000 : 4'b0001);
            tick();
        end
        check("t1_gap_grant", grant_a, 4'b0000);
        check("t1_gap_rd", rd_a, 1'b0);
        check("t1_gap_busy", busy_a, 1'b0);
        check("t1_gap_valid", valid_a, 4'b0001);
        tick();
        check("t1_regrant", grant_a, 4'b0001);
        check("t1_regrant_valid", valid_a, 4'b0000);

        // ---- all four request, FIFO never empty ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_a = 4'b1111;
        settle();
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << (g % 4);
            tick();
            for (int i = 0; i < 8; i++) begin
                check("t2_grant", grant_a, exp_g);
                check("t2_rd", rd_a, 1'b1);
                check("t2_valid", valid_a, (i == 0) ? 4'b0000 : exp_g);
                tick();
            end
            check("t2_gap_grant", grant_a, 4'b0000);
            check("t2_gap_rd", rd_a, 1'b0);
            check("t2_gap_valid", valid_a, exp_g);
        end

        // ---- owner 2, FIFO empty for 5 cycles after read 3 ----
        reset = 1'b1;
        req_a = '0;
        tick();
        reset = 1'b0;
        req_a = 4'b0100;
        settle();
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t3_rd_pre", rd_a, 1'b1);
            tick();
        end
        empty = 1'b1;
        settle();
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_rd", rd_a, 1'b0);
            check("t3_stall_grant", grant_a, 4'b0100);
            check("t3_stall_busy", busy_a, 1'b1);
            tick();
        end
        empty = 1'b0;
        settle();
        for (int i = 0; i < 5; i++) begin
            check("t3_rd_post", rd_a, 1'b1);
            check("t3_grant_post", grant_a, 4'b0100);
            tick();
        end
        check("t3_end_grant", grant_a, 4'b0000);
        check("t3_end_rd", rd_a, 1'b0);

        // ---- owner 1 drops request after read 2 ----
        reset = 1'b1;
        req_a = '0;
        tick();
        reset = 1'b0;
        req_a = 4'b1010;
        settle();
        tick();
        check("t4_grant", grant_a, 4'b0010);
        check("t4_rd1", rd_a, 1'b1);
        tick();
        check("t4_rd2", rd_a, 1'b1);
        check("t4_valid1", valid_a, 4'b0010);
        tick();
        req_a = 4'b1000;
        settle();
        check("t4_drop_rd", rd_a, 1'b0);
        check("t4_valid2", valid_a, 4'b0010);
        tick();
        check("t4_idle_grant", grant_a, 4'b0000);
        check("t4_idle_valid", valid_a, 4'b0000);
        tick();
        check("t4_next_grant", grant_a, 4'b1000);

        // ---- READ_LAT=2, reset with two tags in flight ----
        reset = 1'b1;
        req_a = '0;
        tick();
        reset = 1'b0;
        req_b = 4'b0001;
        settle();
        tick();
        tick();
        check("t5_lat2_early", valid_b, 4'b0000);
        tick();
        check("t5_lat2_valid", valid_b, 4'b0001);
        repeat (6) tick();
        check("t5_idle_grant", grant_b, 4'b0000);
        check("t5_idle_valid", valid_b, 4'b0001);
        tick();
        check("t5_regrant", grant_b, 4'b0001);
        tick();
        tick();
        reset = 1'b1;
        req_b = 4'b0011;
        settle();
        check("t5_rd_in_reset", rd_b, 1'b0);
        tick();
        reset = 1'b0;
        settle();
        check("t5_post_grant", grant_b, 4'b0000);
        check("t5_post_valid", valid_b, 4'b0000);
        check("t5_post_busy", busy_b, 1'b0);
        check("t5_post_rd", rd_b, 1'b0);
        tick();
        check("t5_tag_discard", valid_b, 4'b0000);
        check("t5_restart_core0", grant_b, 4'b0001);

        // ---- N_REQ=3, cores 0 and 2 alternate ----
        reset = 1'b1;
        req_b = '0;
        tick();
        reset = 1'b0;
        req_c = 3'b101;
        settle();
        exp_c[0] = 3'b001;
        exp_c[1] = 3'b100;
        exp_c[2] = 3'b001;
        exp_c[3] = 3'b100;
        for (int g = 0; g < 4; g++) begin
            tick();
            check("t6_grant", grant_c, exp_c[g]);
            check("t6_rd", rd_c, 1'b1);
            repeat (8) tick();
            check("t6_gap_grant", grant_c, 3'b000);
        end
        req_c = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
